// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller.
//   hz_state_e   - controller state encoding (run, mult/div busy, branch flush)
//   MD_MUL_LAT   - mult occupancy in cycles
//   MD_DIV_LAT   - div occupancy in cycles
//   MD_CNT_W     - width of the mult/div busy down-counter
//   md_init()    - counter preload for a mult/div start (latency minus one)
package hazard_pkg;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StMdBusy = 2'd1,
    StFlush  = 2'd2
  } hz_state_e;

  localparam int unsigned MD_MUL_LAT = 4;
  localparam int unsigned MD_DIV_LAT = 32;
  localparam int unsigned MD_CNT_W   = 5;

  // The busy state is left on the edge where the counter reads zero, so a
  // preload of latency-1 yields exactly 'latency' stalled cycles.
  function automatic logic [MD_CNT_W-1:0] md_init(input logic is_div);
    return is_div ? MD_CNT_W'(MD_DIV_LAT - 1) : MD_CNT_W'(MD_MUL_LAT - 1);
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// md_busy_cnt: loadable down-counter tracking remaining mult/div busy cycles.
// State updates on the falling edge of clk, matching the pipeline registers.
// Ports:
//   clk      - clock (falling-edge active)
//   rst      - synchronous active-high reset, clears the count
//   clr      - synchronous clear (operation cancelled)
//   load     - load load_val
//   load_val - preload value
//   dec      - decrement request; holds at zero
//   cnt      - current count
//   zero     - count equals zero
module md_busy_cnt
  import hazard_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                load,
  input  logic [MD_CNT_W-1:0] load_val,
  input  logic                dec,
  output logic [MD_CNT_W-1:0] cnt,
  output logic                zero
);

  logic [MD_CNT_W-1:0] cnt_q;

  always_ff @(negedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller.
// Handles load-use stalls, taken-branch flushes and (optionally) multi-cycle
// mult/div occupancy. All state updates on the falling edge of clk.
// Optional feature: define HAZARD_MULDIV_EN to include the mult/div busy state,
// its down-counter (md_busy_cnt) and Md_Busy. Without it Ex_MdStart/Ex_MdDiv
// are ignored and Md_Busy is tied low.
// Ports:
//   clk, rst              - clock (falling edge), synchronous active-high reset
//   ID_Rs, ID_Rt          - source registers of the ID instruction
//   ID_UsesRt             - ID instruction reads Rt
//   Ex_MemRd, Ex_Rw       - EX instruction is a load / its destination
//   Ex_MdStart, Ex_MdDiv  - mult/div issued in EX, 1=div 0=mult
//   Mem_Taken             - branch in MEM resolved taken
//   PC_Wr, IF_ID_Wr, ID_Ex_Wr            - hold-enables (0 = hold)
//   IF_ID_Flush, ID_Ex_Flush, Ex_Mem_Flush - bubble inserts
//   PC_Src                - select the MEM branch target
//   Md_Busy               - mult/div in progress
//   Stall_Cnt             - saturating count of cycles with PC_Wr=0
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        Ex_MemRd,
  input  logic [4:0]  Ex_Rw,
  input  logic        Ex_MdStart,
  input  logic        Ex_MdDiv,
  input  logic        Mem_Taken,
  output logic        PC_Wr,
  output logic        IF_ID_Wr,
  output logic        ID_Ex_Wr,
  output logic        IF_ID_Flush,
  output logic        ID_Ex_Flush,
  output logic        Ex_Mem_Flush,
  output logic        PC_Src,
  output logic        Md_Busy,
  output logic [15:0] Stall_Cnt
);

  hz_state_e   state_q;
  logic [15:0] stall_q;
  logic        load_use;
  logic        in_md;
  logic        md_start;
  logic        md_zero;

  // r0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign load_use = Ex_MemRd && (Ex_Rw != 5'd0) &&
                    ((Ex_Rw == ID_Rs) || (ID_UsesRt && (Ex_Rw == ID_Rt)));

`ifdef HAZARD_MULDIV_EN
  logic [MD_CNT_W-1:0] md_cnt;

  // Load-use wins over a same-cycle start; the start is re-presented later.
  assign md_start = (state_q == StRun) && !Mem_Taken && !load_use && Ex_MdStart;
  assign in_md    = (state_q == StMdBusy);

  md_busy_cnt u_md_busy_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (Mem_Taken),
    .load     (md_start),
    .load_val (md_init(Ex_MdDiv)),
    .dec      (in_md),
    .cnt      (md_cnt),
    .zero     (md_zero)
  );
`else
  logic md_unused;

  assign md_unused = Ex_MdStart ^ Ex_MdDiv;
  assign md_start  = 1'b0;
  assign md_zero   = 1'b1;
  assign in_md     = 1'b0;
`endif

  // Outputs are combinational so hazards act in the cycle they are seen.
  always_comb begin
    PC_Wr        = 1'b1;
    IF_ID_Wr     = 1'b1;
    ID_Ex_Wr     = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_Ex_Flush  = 1'b0;
    Ex_Mem_Flush = 1'b0;
    PC_Src       = 1'b0;
    if (!rst) begin
      if (Mem_Taken) begin
        // The branch is older than anything behind it: redirect and squash.
        PC_Src       = 1'b1;
        IF_ID_Flush  = 1'b1;
        ID_Ex_Flush  = 1'b1;
        Ex_Mem_Flush = 1'b1;
      end else if (in_md) begin
        PC_Wr        = 1'b0;
        IF_ID_Wr     = 1'b0;
        ID_Ex_Wr     = 1'b0;
        Ex_Mem_Flush = 1'b1;
      end else if ((state_q == StRun) && load_use) begin
        PC_Wr       = 1'b0;
        IF_ID_Wr    = 1'b0;
        ID_Ex_Flush = 1'b1;
      end
    end
  end

  assign Md_Busy   = in_md && !rst;
  assign Stall_Cnt = stall_q;

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= StRun;
      stall_q <= '0;
    end else begin
      if (!PC_Wr && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      if (Mem_Taken) begin
        state_q <= StFlush;
      end else begin
        case (state_q)
          StRun:    if (md_start) state_q <= StMdBusy;
          StMdBusy: if (md_zero) state_q <= StRun;
          StFlush:  state_q <= StRun;
          default:  state_q <= StRun;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

`ifdef HAZARD_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [4:0]  ID_Rs, ID_Rt, Ex_Rw;
  logic        ID_UsesRt, Ex_MemRd, Ex_MdStart, Ex_MdDiv, Mem_Taken;
  logic        PC_Wr, IF_ID_Wr, ID_Ex_Wr, IF_ID_Flush, ID_Ex_Flush, Ex_Mem_Flush;
  logic        PC_Src, Md_Busy;
  logic [15:0] Stall_Cnt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .ID_Rs        (ID_Rs),
    .ID_Rt        (ID_Rt),
    .ID_UsesRt    (ID_UsesRt),
    .Ex_MemRd     (Ex_MemRd),
    .Ex_Rw        (Ex_Rw),
    .Ex_MdStart   (Ex_MdStart),
    .Ex_MdDiv     (Ex_MdDiv),
    .Mem_Taken    (Mem_Taken),
    .PC_Wr        (PC_Wr),
    .IF_ID_Wr     (IF_ID_Wr),
    .ID_Ex_Wr     (ID_Ex_Wr),
    .IF_ID_Flush  (IF_ID_Flush),
    .ID_Ex_Flush  (ID_Ex_Flush),
    .Ex_Mem_Flush (Ex_Mem_Flush),
    .PC_Src       (PC_Src),
    .Md_Busy      (Md_Busy),
    .Stall_Cnt    (Stall_Cnt)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Reference model: remaining busy cycles, pending flush cycle, stall count.
  int m_busy  = 0;
  bit m_flush = 1'b0;
  int m_stall = 0;

  bit e_pc_wr, e_ifid_wr, e_idex_wr, e_ifid_fl, e_idex_fl, e_exmem_fl, e_pc_src, e_busy;
  bit lu_now;

  always_comb begin
    lu_now = Ex_MemRd && (Ex_Rw != 0) &&
             ((Ex_Rw == ID_Rs) || (ID_UsesRt && (Ex_Rw == ID_Rt)));
    e_pc_wr = 1; e_ifid_wr = 1; e_idex_wr = 1;
    e_ifid_fl = 0; e_idex_fl = 0; e_exmem_fl = 0; e_pc_src = 0;
    e_busy = !rst && (m_busy > 0);
    if (!rst) begin
      if (Mem_Taken) begin
        e_pc_src = 1; e_ifid_fl = 1; e_idex_fl = 1; e_exmem_fl = 1;
      end else if (m_busy > 0) begin
        e_pc_wr = 0; e_ifid_wr = 0; e_idex_wr = 0; e_exmem_fl = 1;
      end else if (!m_flush && lu_now) begin
        e_pc_wr = 0; e_ifid_wr = 0; e_idex_fl = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      m_busy  <= 0;
      m_flush <= 1'b0;
      m_stall <= 0;
    end else begin
      if (!e_pc_wr) m_stall <= (m_stall == 65535) ? 65535 : m_stall + 1;
      if (Mem_Taken) begin
        m_flush <= 1'b1;
        m_busy  <= 0;
      end else if (m_busy > 0) begin
        m_busy <= m_busy - 1;
      end else if (m_flush) begin
        m_flush <= 1'b0;
      end else if (!lu_now && Ex_MdStart && MD) begin
        m_busy <= Ex_MdDiv ? int'(32) : int'(4);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison, mid-cycle on the non-active edge.
  always @(posedge clk) begin
    if (chk_en) begin
      check("cyc_pc_wr",      32'(PC_Wr),        32'(e_pc_wr));
      check("cyc_if_id_wr",   32'(IF_ID_Wr),     32'(e_ifid_wr));
      check("cyc_id_ex_wr",   32'(ID_Ex_Wr),     32'(e_idex_wr));
      check("cyc_if_id_fl",   32'(IF_ID_Flush),  32'(e_ifid_fl));
      check("cyc_id_ex_fl",   32'(ID_Ex_Flush),  32'(e_idex_fl));
      check("cyc_ex_mem_fl",  32'(Ex_Mem_Flush), 32'(e_exmem_fl));
      check("cyc_pc_src",     32'(PC_Src),       32'(e_pc_src));
      check("cyc_md_busy",    32'(Md_Busy),      32'(e_busy));
      check("cyc_stall_cnt",  32'(Stall_Cnt),    32'(m_stall));
    end
  end

  task automatic idle();
    ID_Rs = 5'd1; ID_Rt = 5'd2; ID_UsesRt = 1'b0; Ex_MemRd = 1'b0; Ex_Rw = 5'd0;
    Ex_MdStart = 1'b0; Ex_MdDiv = 1'b0; Mem_Taken = 1'b0;
  endtask

  task automatic at_pos();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    at_neg();
    rst = 1'b0;
  endtask

  int n_busy;

  initial begin
    idle();
    rst = 1'b1;
    at_neg();
    chk_en = 1'b1;
    at_pos();
    check("rst_hold_pcwr", 32'(PC_Wr), 32'd1);
    at_neg();
    rst = 1'b0;
    check("rst_stall", 32'(Stall_Cnt), 32'd0);
    check("rst_busy", 32'(Md_Busy), 32'd0);

    // Load-use on Rs
    Ex_MemRd = 1; Ex_Rw = 5'd5; ID_Rs = 5'd5;
    at_pos();
    check("lu_pcwr", 32'(PC_Wr), 32'd0);
    check("lu_idex_fl", 32'(ID_Ex_Flush), 32'd1);
    check("lu_ifid_wr", 32'(IF_ID_Wr), 32'd0);
    at_neg();
    idle();
    check("lu_cnt", 32'(Stall_Cnt), 32'd1);
    check("lu_model_cnt", 32'(m_stall), 32'd1);
    at_pos();
    check("lu_one_cycle", 32'(PC_Wr), 32'd1);

    // No false hazards
    at_neg();
    Ex_MemRd = 1; Ex_Rw = 5'd0; ID_Rs = 5'd0;
    at_pos();
    check("nf_r0", 32'(PC_Wr), 32'd1);
    at_neg();
    Ex_Rw = 5'd7; ID_Rt = 5'd7; ID_Rs = 5'd3; ID_UsesRt = 0;
    at_pos();
    check("nf_rt_unused", 32'(PC_Wr), 32'd1);
    at_neg();
    ID_UsesRt = 1;
    at_pos();
    check("rt_hit", 32'(PC_Wr), 32'd0);
    at_neg();
    idle();
    check("nf_cnt", 32'(Stall_Cnt), 32'd2);

    // Taken branch beats a simultaneous load-use
    Mem_Taken = 1; Ex_MemRd = 1; Ex_Rw = 5'd4; ID_Rs = 5'd4;
    at_pos();
    check("br_pc_src", 32'(PC_Src), 32'd1);
    check("br_flushes", {29'd0, IF_ID_Flush, ID_Ex_Flush, Ex_Mem_Flush}, 32'd7);
    check("br_pcwr", 32'(PC_Wr), 32'd1);
    at_neg();
    Mem_Taken = 0;
    at_pos();
    check("fl_clean_pcwr", 32'(PC_Wr), 32'd1);
    check("fl_clean_flush", {29'd0, IF_ID_Flush, ID_Ex_Flush, Ex_Mem_Flush}, 32'd0);
    check("fl_pc_src", 32'(PC_Src), 32'd0);
    at_neg();
    at_pos();
    check("br_back_run", 32'(PC_Wr), 32'd0);
    at_neg();
    idle();
    check("br_cnt", 32'(Stall_Cnt), 32'd3);

    // Div: 32 busy cycles
    do_reset();
    Ex_MdStart = 1; Ex_MdDiv = 1;
    at_neg();
    idle();
    n_busy = 0;
    repeat (40) begin
      at_pos();
      if (Md_Busy) n_busy++;
      at_neg();
    end
    check("div_busy", 32'(n_busy), MD ? 32'd32 : 32'd0);
    check("div_stall", 32'(Stall_Cnt), MD ? 32'd32 : 32'd0);

    // Mult: 4 busy cycles
    do_reset();
    Ex_MdStart = 1; Ex_MdDiv = 0;
    at_neg();
    idle();
    n_busy = 0;
    repeat (10) begin
      at_pos();
      if (Md_Busy) n_busy++;
      at_neg();
    end
    check("mul_busy", 32'(n_busy), MD ? 32'd4 : 32'd0);
    check("mul_stall", 32'(Stall_Cnt), MD ? 32'd4 : 32'd0);

    // Branch in the 10th div cycle cancels the div
    do_reset();
    Ex_MdStart = 1; Ex_MdDiv = 1;
    at_neg();
    idle();
    repeat (9) begin
      at_pos();
      at_neg();
    end
    Mem_Taken = 1;
    at_pos();
    check("cx_busy_still", 32'(Md_Busy), MD ? 32'd1 : 32'd0);
    check("cx_pc_src", 32'(PC_Src), 32'd1);
    at_neg();
    Mem_Taken = 0;
    check("cx_stall", 32'(Stall_Cnt), MD ? 32'd9 : 32'd0);
    at_pos();
    check("cx_busy_gone", 32'(Md_Busy), 32'd0);
    check("cx_pcwr", 32'(PC_Wr), 32'd1);
    at_neg();

    // Reset mid-div
    do_reset();
    Ex_MdStart = 1; Ex_MdDiv = 1;
    at_neg();
    idle();
    repeat (5) at_neg();
    do_reset();
    check("rd_stall", 32'(Stall_Cnt), 32'd0);
    at_pos();
    check("rd_busy", 32'(Md_Busy), 32'd0);
    check("rd_pcwr", 32'(PC_Wr), 32'd1);
    at_neg();
    Ex_MemRd = 1; Ex_Rw = 5'd9; ID_Rt = 5'd9; ID_UsesRt = 1;
    at_pos();
    check("rd_normal_lu", 32'(PC_Wr), 32'd0);
    at_neg();
    idle();

    // Randomized traffic checked by the per-cycle comparison
    repeat (3000) begin
      rst        = ($urandom_range(0, 99) == 0);
      ID_Rs      = 5'($urandom_range(0, 3));
      ID_Rt      = 5'($urandom_range(0, 3));
      ID_UsesRt  = 1'($urandom_range(0, 1));
      Ex_MemRd   = ($urandom_range(0, 9) < 4);
      Ex_Rw      = 5'($urandom_range(0, 3));
      Ex_MdStart = ($urandom_range(0, 99) < 8);
      Ex_MdDiv   = ($urandom_range(0, 9) < 3);
      Mem_Taken  = ($urandom_range(0, 99) < 4);
      at_neg();
    end
    rst = 1'b0;
    idle();
    at_neg();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on the falling edge, the same edge the pipeline registers use.
REQ-002 SHALL have port rst, input, 1, reset: synchronous and active-high.
REQ-003 SHALL have ports ID_Rs and ID_Rt, inputs, 5 each, source register numbers of the instruction in ID.
REQ-004 SHALL have port ID_UsesRt, input, 1, high when the ID instruction reads Rt.
REQ-005 SHALL have port Ex_MemRd, input, 1, high when the EX instruction is a load.
REQ-006 SHALL have port Ex_Rw, input, 5, destination register of the EX instruction.
REQ-007 SHALL have ports Ex_MdStart, input, 1, and Ex_MdDiv, input, 1: a mult/div op in EX, and 1=div, 0=mult.
REQ-008 SHALL have port Mem_Taken, input, 1, branch resolved taken in MEM.
REQ-009 SHALL have outputs PC_Wr, IF_ID_Wr, ID_Ex_Wr, 1 each: hold-enables, where 0 means hold.
REQ-010 SHALL have outputs IF_ID_Flush, ID_Ex_Flush, Ex_Mem_Flush, 1 each: load a bubble of all control bits zero.
REQ-011 SHALL have outputs PC_Src, 1, select Mem_branch_addr; Md_Busy, 1; Stall_Cnt, 16, stalled-cycle count.

Function
REQ-012 SHALL implement the states RUN, MDBUSY and FLUSH.
REQ-013 SHALL, in RUN with no event, drive all write-enables to 1, all flushes to 0 and PC_Src to 0.
REQ-014 SHALL detect a load-use hazard: Ex_MemRd=1, Ex_Rw!=0, and Ex_Rw==ID_Rs or (ID_UsesRt=1 and Ex_Rw==ID_Rt).
REQ-015 SHALL respond to a load-use hazard in RUN, combinationally in the same cycle, with PC_Wr=0, IF_ID_Wr=0 and ID_Ex_Flush=1, for exactly one cycle; the state stays RUN.
REQ-016 SHALL, on Mem_Taken=1 in any state, assert PC_Src=1, IF_ID_Flush=1, ID_Ex_Flush=1 and Ex_Mem_Flush=1 in that cycle, then go to FLUSH.
REQ-017 SHALL stay in FLUSH one cycle, with all enables 1 and all flushes 0, ignoring load-use, then go to RUN.
REQ-018 SHALL give Mem_Taken priority over MDBUSY and over load-use; a branch in MEM is older, so it cancels the mult/div: the counter is cleared and Md_Busy falls on the next edge.
REQ-019 SHALL, on Ex_MdStart=1 in RUN without Mem_Taken, load the counter with MD_MUL_LAT-1 (=3) or MD_DIV_LAT-1 (=31) and enter MDBUSY.
REQ-020 SHALL, in MDBUSY, drive PC_Wr=0, IF_ID_Wr=0, ID_Ex_Wr=0, Ex_Mem_Flush=1 and Md_Busy=1, and decrement the counter each edge.
REQ-021 SHALL go from MDBUSY to RUN on the edge where the counter is 0, so that mult stalls 4 cycles and div stalls 32; Ex_MdStart is ignored while busy.
REQ-022 SHALL give load-use priority over Ex_MdStart in the same RUN cycle: the mult/div is not started until the load bubble has passed.
REQ-023 SHALL increment Stall_Cnt on every edge where PC_Wr=0, saturating at 16'hFFFF.

Reset
REQ-024 SHALL, with rst=1 at a falling edge, go to state RUN, set the counter to 0 and set Stall_Cnt to 0, overriding any event in that cycle.
REQ-025 SHALL hold outputs at their RUN defaults while rst=1: enables 1, flushes 0, PC_Src 0, Md_Busy 0.
REQ-026 SHALL let a reset during MDBUSY or FLUSH abandon that operation with no residual stall.

Configuration
REQ-027 SHALL, with HAZARD_MULDIV_EN defined, include MDBUSY, the counter and Md_Busy.
REQ-028 SHALL, without HAZARD_MULDIV_EN, omit MDBUSY and the counter, ignore Ex_MdStart and Ex_MdDiv, and tie Md_Busy to 0.

Structure
REQ-029 SHALL place the state encoding and MD_MUL_LAT=4 and MD_DIV_LAT=32 in the shared package hazard_pkg.
REQ-030 SHALL implement the loadable down-counter as sub-module md_busy_cnt, instantiated only under HAZARD_MULDIV_EN.

Verification
REQ-031 SHALL cover load-use: Ex_MemRd=1, Ex_Rw=5, ID_Rs=5 -> one cycle of PC_Wr=0 and ID_Ex_Flush=1, and Stall_Cnt goes 0->1.
REQ-032 SHALL cover no false hazards: Ex_Rw=0, or ID_Rt match with ID_UsesRt=0 -> no stall.
REQ-033 SHALL cover a taken branch: Mem_Taken=1 -> PC_Src=1 and three flushes in the same cycle, then one clean FLUSH cycle, then RUN.
REQ-034 SHALL cover div: Ex_MdStart=1, Ex_MdDiv=1 -> Md_Busy high for exactly 32 edges and Stall_Cnt=32; mult gives 4.
REQ-035 SHALL cover Mem_Taken in the 10th div cycle -> div cancelled and Md_Busy=0 after the next edge.
REQ-036 SHALL cover rst=1 mid-div -> RUN, Stall_Cnt=0, and normal flow on the next cycle.
